// File: rtl/irq_sched_pkg.sv
// Shared defaults and FSM state type for the irq_sched interrupt scheduler.
package irq_sched_pkg;

  localparam int NUM_CH_DEF = 9;
  localparam int ID_W_DEF   = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    SERVICE = 2'd2
  } state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational winner select: first set bit of eligible at or after start,
// wrapping modulo NUM_CH. start = 0 gives plain fixed priority (bit 0 highest).
module irq_prio_enc #(
  parameter int NUM_CH = 9,
  parameter int ID_W   = 4
) (
  input  logic [NUM_CH-1:0] eligible,
  input  logic [ID_W-1:0]   start,
  output logic              any,
  output logic [ID_W-1:0]   id
);

  localparam int IW = ID_W + 1;

  logic [IW-1:0] idx;

  // Scan from the farthest offset down so the nearest hit to start is the last write.
  always_comb begin
    any = 1'b0;
    id  = '0;
    idx = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = {1'b0, start} + IW'(k);
      if (idx >= IW'(NUM_CH)) begin
        idx = idx - IW'(NUM_CH);
      end
      if (eligible[idx[ID_W-1:0]]) begin
        any = 1'b1;
        id  = idx[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/irq_sched9.sv
// Interrupt scheduler: pending latch, IDLE/GRANT/SERVICE handshake with the CPU.
// Define IRQ_SCHED_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority.
module irq_sched9
  import irq_sched_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int ID_W   = ID_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] req_i,
  input  logic [NUM_CH-1:0] mask_i,
  input  logic              ack_i,
  input  logic              eoi_i,
  output logic              irq_o,
  output logic [ID_W-1:0]   vec_o,
  output logic [NUM_CH-1:0] pend_o,
  output logic              busy_o
);

  // Handshake: irq_o is the valid for vec_o; ack_i is accepted only while in
  // GRANT, eoi_i only while in SERVICE, and both are ignored elsewhere.

  state_e            state;
  logic [NUM_CH-1:0] pend;
  logic [NUM_CH-1:0] eligible;
  logic [NUM_CH-1:0] clr;
  logic [ID_W-1:0]   start;
  logic [ID_W-1:0]   win_id;
  logic              win_any;
  logic              ack_take;
  logic              withdraw;

  assign eligible = pend & ~mask_i;
  assign ack_take = (state == GRANT) && ack_i;
  assign withdraw = (state == GRANT) && !ack_i && mask_i[vec_o];
  assign clr      = ack_take ? ({{(NUM_CH-1){1'b0}}, 1'b1} << vec_o) : '0;
  assign busy_o   = (state != IDLE);
  assign pend_o   = pend;

  // A new request on the ack edge wins over the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= '0;
    end else begin
      pend <= (pend & ~clr) | req_i;
    end
  end

`ifdef IRQ_SCHED_ROUND_ROBIN_EN
  logic [ID_W-1:0] ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (ack_take) begin
      ptr <= (vec_o == ID_W'(NUM_CH - 1)) ? '0 : vec_o + 1'b1;
    end
  end

  assign start = ptr;
`else
  assign start = '0;
`endif

  irq_prio_enc #(
    .NUM_CH (NUM_CH),
    .ID_W   (ID_W)
  ) u_prio_enc (
    .eligible (eligible),
    .start    (start),
    .any      (win_any),
    .id       (win_id)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      irq_o <= 1'b0;
      vec_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_any) begin
            state <= GRANT;
            irq_o <= 1'b1;
            vec_o <= win_id;
          end
        end
        GRANT: begin
          if (ack_take) begin
            state <= SERVICE;
            irq_o <= 1'b0;
          end else if (withdraw) begin
            state <= IDLE;
            irq_o <= 1'b0;
          end
        end
        SERVICE: begin
          if (eoi_i) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          irq_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_sched9.sv
// Bench for irq_sched9: directed scenarios plus random traffic checked every cycle
// against a behavioural model. Follows IRQ_SCHED_ROUND_ROBIN_EN like the design.
module tb_irq_sched9;

  localparam int NUM_CH = 9;
  localparam int ID_W   = 4;
`ifdef IRQ_SCHED_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [NUM_CH-1:0] req_i;
  logic [NUM_CH-1:0] mask_i;
  logic              ack_i;
  logic              eoi_i;
  logic              irq_o;
  logic [ID_W-1:0]   vec_o;
  logic [NUM_CH-1:0] pend_o;
  logic              busy_o;

  int vectors     = 0;
  int miscompares = 0;

  // Model: mode 0 = nothing offered, 1 = vector offered, 2 = being serviced
  logic [NUM_CH-1:0] m_pend;
  int                m_mode;
  int                m_vec;
  logic              m_irq;
  int                m_ptr;

  always #5 clk = ~clk;

  irq_sched9 #(
    .NUM_CH (NUM_CH),
    .ID_W   (ID_W)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .req_i  (req_i),
    .mask_i (mask_i),
    .ack_i  (ack_i),
    .eoi_i  (eoi_i),
    .irq_o  (irq_o),
    .vec_o  (vec_o),
    .pend_o (pend_o),
    .busy_o (busy_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [NUM_CH-1:0] elig, input int from);
    logic [NUM_CH-1:0] sh;
    for (int k = 0; k < NUM_CH; k++) begin
      sh = elig >> ((from + k) % NUM_CH);
      if (sh[0]) return (from + k) % NUM_CH;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_pend = '0;
    m_mode = 0;
    m_vec  = 0;
    m_irq  = 1'b0;
    m_ptr  = 0;
  endtask

  task automatic model_step(input logic [NUM_CH-1:0] rq, input logic [NUM_CH-1:0] mk,
                            input logic ak, input logic eo);
    logic [NUM_CH-1:0] clr;
    logic [NUM_CH-1:0] sh;
    int w;
    clr = '0;
    case (m_mode)
      0: begin
        w = pick(m_pend & ~mk, RR ? m_ptr : 0);
        if (w >= 0) begin
          m_mode = 1;
          m_irq  = 1'b1;
          m_vec  = w;
        end
      end
      1: begin
        sh = mk >> m_vec;
        if (ak) begin
          clr    = NUM_CH'(1) << m_vec;
          m_mode = 2;
          m_irq  = 1'b0;
          m_ptr  = (m_vec + 1) % NUM_CH;
        end else if (sh[0]) begin
          m_mode = 0;
          m_irq  = 1'b0;
        end
      end
      default: begin
        if (eo) m_mode = 0;
      end
    endcase
    m_pend = (m_pend & ~clr) | rq;
  endtask

  // Cycle-by-cycle compare against the model, 2 time units after each edge.
  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (rst) model_reset();
      else model_step(req_i, mask_i, ack_i, eoi_i);
      #2;
      if (!rst) begin
        check("cyc_irq",  32'(irq_o),  32'(m_irq));
        check("cyc_vec",  32'(vec_o),  32'(m_vec));
        check("cyc_pend", 32'(pend_o), 32'(m_pend));
        check("cyc_busy", 32'(busy_o), 32'(m_mode != 0));
      end
    end
  end

  task automatic cyc(input logic [NUM_CH-1:0] rq, input logic [NUM_CH-1:0] mk,
                     input logic ak, input logic eo);
    @(negedge clk);
    req_i  = rq;
    mask_i = mk;
    ack_i  = ak;
    eoi_i  = eo;
    @(posedge clk);
    #3;
  endtask

  task automatic ack_eoi();
    cyc('0, '0, 1'b1, 1'b0);
    cyc('0, '0, 1'b0, 1'b1);
  endtask

  initial begin
    logic [NUM_CH-1:0] rq;
    logic [NUM_CH-1:0] mk;
    rst    = 1'b1;
    req_i  = '0;
    mask_i = '0;
    ack_i  = 1'b0;
    eoi_i  = 1'b0;
    #1;
    check("rst_irq",  32'(irq_o),  32'd0);
    check("rst_pend", 32'(pend_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_vec",  32'(vec_o),  32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Single request: pend, then irq one cycle later, ack, eoi
    cyc(9'h010, '0, 1'b0, 1'b0);
    check("t1_pend", 32'(pend_o), 32'h010);
    check("t1_irq0", 32'(irq_o),  32'd0);
    cyc('0, '0, 1'b0, 1'b0);
    check("t1_irq1", 32'(irq_o),  32'd1);
    check("t1_vec",  32'(vec_o),  32'd4);
    cyc('0, '0, 1'b1, 1'b0);
    check("t1_ackpend", 32'(pend_o), 32'd0);
    check("t1_ackirq",  32'(irq_o),  32'd0);
    check("t1_ackbusy", 32'(busy_o), 32'd1);
    cyc('0, '0, 1'b0, 1'b1);
    check("t1_eoibusy", 32'(busy_o), 32'd0);

    // Two simultaneous requests
    cyc(9'h0A0, '0, 1'b0, 1'b0);
    cyc('0, '0, 1'b0, 1'b0);
    check("t2_vec5", 32'(vec_o), 32'd5);
    ack_eoi();
    cyc('0, '0, 1'b0, 1'b0);
    check("t2_vec7", 32'(vec_o), 32'd7);
    check("t2_irq",  32'(irq_o), 32'd1);
    ack_eoi();

    // Withdrawal by mask, then re-grant after unmask
    cyc(9'h008, '0, 1'b0, 1'b0);
    cyc('0, '0, 1'b0, 1'b0);
    check("t3_vec", 32'(vec_o), 32'd3);
    cyc('0, 9'h008, 1'b0, 1'b0);
    check("t3_wirq",  32'(irq_o),  32'd0);
    check("t3_wpend", 32'(pend_o), 32'h008);
    check("t3_wbusy", 32'(busy_o), 32'd0);
    cyc('0, '0, 1'b0, 1'b0);
    check("t3_regrant", 32'(irq_o), 32'd1);
    check("t3_revec",   32'(vec_o), 32'd3);
    ack_eoi();

    // Set beats clear on the ack edge
    cyc(9'h004, '0, 1'b0, 1'b0);
    cyc('0, '0, 1'b0, 1'b0);
    check("t4_vec", 32'(vec_o), 32'd2);
    cyc(9'h004, '0, 1'b1, 1'b0);
    check("t4_pend", 32'(pend_o), 32'h004);
    check("t4_irq",  32'(irq_o),  32'd0);
    cyc('0, '0, 1'b0, 1'b1);
    check("t4_eoipend", 32'(pend_o), 32'h004);
    cyc('0, '0, 1'b0, 1'b0);
    check("t4_regrant", 32'(irq_o), 32'd1);
    check("t4_revec",   32'(vec_o), 32'd2);
    ack_eoi();

    // Arbitration order; ptr is 3 here in round-robin builds
    if (RR) begin
      cyc(9'h020, '0, 1'b0, 1'b0);
      cyc('0, '0, 1'b0, 1'b0);
      check("t5_vec5", 32'(vec_o), 32'd5);
      ack_eoi();
      cyc(9'h041, '0, 1'b0, 1'b0);
      cyc('0, '0, 1'b0, 1'b0);
      check("t5_vec6", 32'(vec_o), 32'd6);
      ack_eoi();
      cyc('0, '0, 1'b0, 1'b0);
      check("t5_vec0", 32'(vec_o), 32'd0);
      ack_eoi();
      cyc(9'h100, '0, 1'b0, 1'b0);
      cyc('0, '0, 1'b0, 1'b0);
      check("t5_vec8", 32'(vec_o), 32'd8);
      ack_eoi();
      cyc(9'h101, '0, 1'b0, 1'b0);
      cyc('0, '0, 1'b0, 1'b0);
      check("t5_wrap0", 32'(vec_o), 32'd0);
      ack_eoi();
    end else begin
      cyc(9'h041, '0, 1'b0, 1'b0);
      cyc('0, '0, 1'b0, 1'b0);
      check("t5_vec0", 32'(vec_o), 32'd0);
      ack_eoi();
      cyc('0, '0, 1'b0, 1'b0);
      check("t5_vec6", 32'(vec_o), 32'd6);
      ack_eoi();
      cyc(9'h101, '0, 1'b0, 1'b0);
      cyc('0, '0, 1'b0, 1'b0);
      check("t5_fix0", 32'(vec_o), 32'd0);
      ack_eoi();
      cyc('0, '0, 1'b0, 1'b0);
      check("t5_fix8", 32'(vec_o), 32'd8);
      ack_eoi();
    end

    // Asynchronous reset in the middle of a grant
    cyc(9'h002, '0, 1'b0, 1'b0);
    cyc('0, '0, 1'b0, 1'b0);
    check("t6_irq", 32'(irq_o), 32'd1);
    @(negedge clk);
    #2;
    rst   = 1'b1;
    req_i = 9'h1FF;
    model_reset();
    #1;
    check("t6_rirq",  32'(irq_o),  32'd0);
    check("t6_rpend", 32'(pend_o), 32'd0);
    check("t6_rbusy", 32'(busy_o), 32'd0);
    check("t6_rvec",  32'(vec_o),  32'd0);
    @(posedge clk);
    #3;
    check("t6_rhold", 32'(pend_o), 32'd0);
    @(negedge clk);
    rst   = 1'b0;
    req_i = '0;
    cyc('0, '0, 1'b0, 1'b0);
    check("t6_post", 32'(pend_o), 32'd0);

    // Random traffic, checked by the compare process
    for (int n = 0; n < 2000; n++) begin
      rq = '0;
      mk = '0;
      for (int b = 0; b < NUM_CH; b++) begin
        if ($urandom_range(0, 99) < 8)  rq = rq | (NUM_CH'(1) << b);
        if ($urandom_range(0, 99) < 10) mk = mk | (NUM_CH'(1) << b);
      end
      cyc(rq, mk, ($urandom_range(0, 99) < 35), ($urandom_range(0, 99) < 35));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
